lsu_rmw: RTL and testbench

LSU_RMW -- requirements
Module: lsu_rmw

---
 rtl/lsu_rmw_pkg.sv | 35 +++
 rtl/lsu_rmw_if.sv | 34 +++
 rtl/lsu_load_align.sv | 31 +++
 rtl/lsu_rmw.sv | 146 ++++++++++++++
 tb/tb_lsu_rmw.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_rmw_pkg.sv
// -----------------------------------------------------------------------------
// lsu_rmw_pkg
// Shared definitions for the load/store unit: FSM state encoding, RISC-V
// funct3 width codes and the request fault classifier used at accept time.
// -----------------------------------------------------------------------------
package lsu_rmw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // A request faults when its funct3 is not a legal width for its
    // direction, or when the address is not naturally aligned to the width.
    function automatic logic req_fault(input logic       we,
                                       input logic [2:0] f3,
                                       input logic [1:0] lo);
        logic illegal;
        logic misaligned;
        illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                     (we && f3[2]);
        misaligned = ((f3[1:0] == 2'b01) && lo[0]) ||
                     ((f3[1:0] == 2'b10) && (lo != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// -----------------------------------------------------------------------------
// lsu_rmw_if
// Core-side request/response bundle of the load/store unit.
//   req_valid/req_ready : request handshake (accept on valid && ready)
//   req_we, req_funct3  : direction and access width
//   req_addr, req_wdata : byte address and right-aligned store data
//   resp_valid          : one-cycle completion pulse
//   resp_rdata          : extended load data (0 for stores and faults)
//   resp_fault          : misaligned or illegal request
// master = core side, slave = load/store unit side.
// -----------------------------------------------------------------------------
interface lsu_rmw_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational lane select and sign/zero extension of a loaded word.
//   word_i   : 32-bit word read from memory
//   lane_i   : byte offset within the word (addr[1:0]), little-endian
//   funct3_i : load width code (LB/LH/LW/LBU/LHU)
//   data_o   : extended load result
// -----------------------------------------------------------------------------
module lsu_load_align
    import lsu_rmw_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end
endmodule

// File: rtl/lsu_rmw.sv
// -----------------------------------------------------------------------------
// lsu_rmw
// Load/store unit in front of a word-wide data memory with a combinational
// read port. Byte and halfword stores are done as read-modify-write.
//   clk, rst   : clock and synchronous active-high reset
//   bus        : core request/response bundle (lsu_rmw_if.slave)
//   mem_WE     : word write enable, only in WRITE and never during reset
//   mem_A      : word-aligned address latched at accept
//   mem_WD     : write word (store data or merged word)
//   mem_RD     : read word, combinational on mem_A
// Sequences: load IDLE->READ->RESP, SW IDLE->WRITE->RESP,
//            SB/SH IDLE->READ->WRITE->RESP, fault IDLE->RESP.
// -----------------------------------------------------------------------------
module lsu_rmw
    import lsu_rmw_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    lsu_rmw_if.slave          bus,
    output logic              mem_WE,
    output logic [ADDR_W-1:0] mem_A,
    output logic [31:0]       mem_WD,
    input  logic [31:0]       mem_RD
);
    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [31:0]       word_q, word_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_fault_q, resp_fault_d;

    logic [31:0]       load_data;
    logic [31:0]       merged;

    lsu_load_align u_align (
        .word_i   (mem_RD),
        .lane_i   (lane_q),
        .funct3_i (f3_q),
        .data_o   (load_data)
    );

    // Byte/halfword merge into the captured word; a full-word store
    // simply passes the store data through.
    always_comb begin
        merged = word_q;
        case (f3_q)
            F3_B:    merged[{lane_q, 3'b000} +: 8]  = wdata_q[7:0];
            F3_H:    merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        mem_a_d      = mem_a_q;
        word_d       = word_q;
        // Response outputs are only ever set on the transition into RESP,
        // so they read as zero in every other state.
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    lane_d  = bus.req_addr[1:0];
                    wdata_d = bus.req_wdata;
                    mem_a_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    if (req_fault(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                word_d = mem_RD;
                if (we_q) begin
                    state_d = WRITE;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
            mem_a_q      <= '0;
            word_q       <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            mem_a_q      <= mem_a_d;
            word_q       <= word_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    // The write enable is gated by rst directly so that a reset arriving
    // while in WRITE kills the write in that same cycle.
    assign mem_WE         = (state_q == WRITE) && !rst;
    assign mem_A          = mem_a_q;
    assign mem_WD         = merged;
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;
endmodule

// File: tb/tb_lsu_rmw.sv
// -----------------------------------------------------------------------------
// tb_lsu_rmw
// Directed bench for lsu_rmw with a word memory model and a response
// scoreboard: each issued request pushes its expected response and latency,
// and a monitor pops and compares on every resp_valid.
// -----------------------------------------------------------------------------
module tb_lsu_rmw;
    logic        clk;
    logic        rst;
    logic        mem_WE;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    lsu_rmw_if #(.ADDR_W(32)) bus ();

    lsu_rmw #(.ADDR_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .mem_WE (mem_WE),
        .mem_A  (mem_A),
        .mem_WD (mem_WD),
        .mem_RD (mem_RD)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [0:63];
    int          cyc;
    int          wr_cnt;
    logic [31:0] last_wa;
    int          resp_cnt;
    int          errors;
    int          checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_RD = mem[mem_A[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_WE) begin
            mem[mem_A[7:2]] <= mem_WD;
            wr_cnt          <= wr_cnt + 1;
            last_wa         <= mem_A;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare data, fault and latency of each response.
    always @(negedge clk) begin
        if (!rst && bus.resp_valid === 1'b1) begin
            exp_t e;
            resp_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
                e = exp_q.pop_front();
                chk("resp_rdata", bus.resp_rdata, e.rdata);
                chk("resp_fault", {31'h0, bus.resp_fault}, {31'h0, e.fault});
                chk("resp_latency", cyc + 1 - e.acc, e.lat);
            end
        end
    end

    // Waits (bounded) for req_ready at a falling edge, then drives the
    // request so it is accepted at the next rising edge. req_valid is left
    // high for the caller to drop.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_f, input int lat, input bit push);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        if (push) begin
            e.rdata = exp_rd;
            e.fault = exp_f;
            e.acc   = cyc + 1;
            e.lat   = lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_f, input int lat);
        send(we, f3, addr, wd, exp_rd, exp_f, lat, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        drain();
    endtask

    initial begin
        int w0;
        int acc_n;
        int acc_e[3];
        int r0;

        cyc      = 0;
        wr_cnt   = 0;
        last_wa  = 32'h0;
        resp_cnt = 0;
        errors   = 0;
        checks   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[5] = 32'hCAFEBABE;   // 0x14
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("reset_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("reset_rdata", bus.resp_rdata, 32'h0);
        chk("reset_mem_we", {31'h0, mem_WE}, 32'h0);
        chk("reset_mem_a", mem_A, 32'h0);

        // SW then LW
        w0 = wr_cnt;
        op(1'b1, 3'b010, 32'h28, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        chk("sw_write_count", wr_cnt - w0, 1);
        chk("sw_write_addr", last_wa, 32'h28);
        chk("sw_mem", mem[10], 32'hDEADBEEF);
        op(1'b0, 3'b010, 32'h28, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        // SB read-modify-write
        w0 = wr_cnt;
        op(1'b1, 3'b000, 32'h29, 32'h00000055, 32'h0, 1'b0, 3);
        chk("sb_write_count", wr_cnt - w0, 1);
        chk("sb_write_addr", last_wa, 32'h28);
        chk("sb_mem", mem[10], 32'hDEAD55EF);

        // Load extension
        op(1'b0, 3'b000, 32'h14, 32'h0, 32'hFFFFFFBE, 1'b0, 2);
        op(1'b0, 3'b100, 32'h14, 32'h0, 32'h000000BE, 1'b0, 2);
        op(1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFFCAFE, 1'b0, 2);
        op(1'b0, 3'b101, 32'h16, 32'h0, 32'h0000CAFE, 1'b0, 2);

        // Faults: misaligned LW, misaligned SH, illegal funct3, store with funct3[2]
        w0 = wr_cnt;
        op(1'b0, 3'b010, 32'h2A, 32'h0, 32'h0, 1'b1, 1);
        op(1'b1, 3'b001, 32'h15, 32'h0000AAAA, 32'h0, 1'b1, 1);
        op(1'b0, 3'b011, 32'h14, 32'h0, 32'h0, 1'b1, 1);
        op(1'b1, 3'b100, 32'h14, 32'h000000AA, 32'h0, 1'b1, 1);
        chk("fault_no_write", wr_cnt - w0, 0);
        chk("fault_mem_14", mem[5], 32'hCAFEBABE);
        chk("fault_mem_28", mem[10], 32'hDEAD55EF);

        // req_valid held for 10 cycles behind a just-accepted LW
        send(1'b0, 3'b010, 32'h28, 32'h0, 32'hDEAD55EF, 1'b0, 2, 1'b1);
        acc_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                exp_t e;
                e.rdata = 32'hDEAD55EF;
                e.fault = 1'b0;
                e.acc   = cyc + 1;
                e.lat   = 2;
                exp_q.push_back(e);
                if (acc_n < 3) acc_e[acc_n] = cyc + 1;
                acc_n++;
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        drain();
        chk("hold_accepts", acc_n, 3);
        if (acc_n >= 3) begin
            chk("hold_gap1", acc_e[1] - acc_e[0], 3);
            chk("hold_gap2", acc_e[2] - acc_e[1], 3);
        end

        // Reset during the WRITE of an SB
        w0 = wr_cnt;
        r0 = resp_cnt;
        send(1'b1, 3'b000, 32'h2A, 32'h00000011, 32'h0, 1'b0, 3, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rmw_reached_write", {31'h0, mem_WE}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_kills_we", {31'h0, mem_WE}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_resp_clear", {31'h0, bus.resp_valid}, 32'h0);
        repeat (4) @(negedge clk);
        chk("rst_no_write", wr_cnt - w0, 0);
        chk("rst_no_resp", resp_cnt - r0, 0);
        chk("rst_mem_28", mem[10], 32'hDEAD55EF);

        // Unit still works after the aborted operation
        op(1'b0, 3'b001, 32'h2A, 32'h0, 32'hFFFFDEAD, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
